exec_arbiter: RTL and testbench
===============================

# exec_arbiter

Shares the single `exec` ALU between NREQ independent requesters, such as the issue stage and the address/branch helper. It accepts one operation at a time over a per-requester valid/ready handshake and drives `exec` from registered operands. It then waits the ALU's registered latency, captures the result, and returns it to the granted requester over a per-requester valid/ready response channel. It sits between the pipeline front end and the `exec` instance.

## Interface
- NREQ, 2: number of requesters, range 2..8
- WIDTH, 32: operand and result width
- OPW, 6: opcode width, matching the `exec` op port
- EXEC_LAT, 1: `exec` clock-to-result latency in cycles, minimum 1
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  request pending, one bit per requester
- req_ready  out  NREQ  request accepted, one-hot or zero
- req_op  in  NREQ*OPW  opcodes, requester i at bits [i*OPW +: OPW]
- req_in1, req_in2  in  NREQ*WIDTH  operands, packed the same way as req_op
- rsp_valid  out  NREQ  result available, one-hot or zero
- rsp_ready  in  NREQ  requester takes the result
- rsp_data  out  WIDTH  result, shared by all requesters
- exec_op  out  OPW  driven to `exec` op
- exec_in1, exec_in2  out  WIDTH  driven to `exec` in1 / in2
- exec_out  in  WIDTH  from `exec` out
- busy  out  1  high whenever the state is not IDLE

## Operation
- State machine states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid is high, pick the grant g and assert req_ready[g] combinationally in the same cycle.
  - On that edge, latch op, in1, in2 and g into registers, clear the latency counter, and go to EXEC.
  - With no requests, stay in IDLE.
- EXEC:
  - exec_* outputs present the latched operands.
  - The counter increments each cycle.
  - The state lasts EXEC_LAT+1 cycles. On its final edge, capture exec_out into the result register and go to RESP.
- RESP:
  - rsp_valid[g]=1 and rsp_data=result, both held stable until rsp_ready[g].
  - On the edge where rsp_ready[g] is high, go to IDLE.
  - rsp_ready on any other index is ignored.
- req_ready is 0 in EXEC and RESP. A requester that drops req_valid before acceptance is simply not served.
- exec_* outputs hold their last operands in IDLE and RESP; `exec` output is ignored outside the capture edge.
- Width rule: the block does no arithmetic. Operands and result pass through unmodified, so wrap-around is whatever `exec` produces.
- Reset:
  - Asserting rst_n mid-operation aborts it; no response is ever issued.
  - State returns to IDLE and the round-robin pointer returns to NREQ-1.
  - Reset values: req_ready=0, rsp_valid=0, rsp_data=0, exec_op=0, exec_in1=0, exec_in2=0, busy=0.

## Timing
- Request accepted in cycle T (req_valid[i] & req_ready[i] at that edge).
- exec_* carry the request from cycle T+1.
- rsp_valid rises in cycle T+EXEC_LAT+2; with EXEC_LAT=1 that is T+3.
- Response handshake at cycle R; the next request is accepted no earlier than R+1.
- Throughput is one operation per EXEC_LAT+3 cycles with zero response backpressure.

## Configuration
- EXEC_ARB_RR_EN defined (round-robin):
  - Search starts at the index after the last granted requester and wraps from NREQ-1 to 0.
  - The pointer updates only on acceptance.
- EXEC_ARB_RR_EN undefined (fixed priority): the lowest-index valid requester always wins, and there is no pointer register.

## Structure
- src/constants.v holds the existing opcode defines, the state encodings `EXEC_ARB_IDLE`, `EXEC_ARB_EXEC` and `EXEC_ARB_RESP`, and the default widths.
- One sub-module, `exec_arb_pick`, is combinational. It takes valid, the pointer and the mode, and returns a one-hot grant plus the encoded index.
- exec_arbiter contains the FSM, the operand/result registers and the latency counter. `exec` is instantiated outside it, at the level above.

## Test plan
- Single ADD: req 0 sends in1=0x00000001, in2=0x00000002, rsp_ready tied high → accepted at T; rsp_valid[0] at T+3 with rsp_data=0x00000003; busy low at T+4.
- Contention (RR): req 0 and req 1 both valid continuously, each doing ADD 5+1 and ADD 7+1 → responses alternate, 0x00000006 to req 0 then 0x00000008 to req 1, repeating.
- Contention (fixed, macro undefined): same stimulus → req 0 is always served and req 1 is starved.
- Backpressure: rsp_ready[0] held low for 5 cycles after rsp_valid → rsp_valid and rsp_data stay stable, req_ready stays 0 for all requesters, and the handshake completes on the 6th cycle.
- Reset mid-EXEC: rst_n pulsed low at T+1 → all outputs go to 0 at once, and no rsp_valid appears.
- Wrap pass-through: ADD 0xFFFFFFFF+0x00000001 → rsp_data=0x00000000, matching exec_out bit-for-bit.

Source files
------------

// File: rtl/exec_arbiter_pkg.sv
// exec_arbiter_pkg
// Shared definitions for the exec arbiter slice: default widths, the
// opcode encodings understood by the downstream `exec` ALU, and the
// arbiter state encoding.
package exec_arbiter_pkg;

  localparam int DEF_NREQ     = 2;
  localparam int DEF_WIDTH    = 32;
  localparam int DEF_OPW      = 6;
  localparam int DEF_EXEC_LAT = 1;

  // Opcodes of the `exec` op port.
  localparam logic [5:0] OP_ADD = 6'h00;
  localparam logic [5:0] OP_SUB = 6'h01;
  localparam logic [5:0] OP_AND = 6'h02;
  localparam logic [5:0] OP_XOR = 6'h03;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } arb_state_e;

endpackage

// File: rtl/exec_arbiter_if.sv
// exec_arbiter_if
// Request/response channels between the requesters and the arbiter.
//   req_valid  requester -> arbiter  one bit per requester
//   req_ready  arbiter -> requester  one-hot or zero
//   req_op     requester -> arbiter  opcodes, requester i at [i*OPW +: OPW]
//   req_in1/2  requester -> arbiter  operands, packed like req_op
//   rsp_valid  arbiter -> requester  one-hot or zero
//   rsp_ready  requester -> arbiter  result taken
//   rsp_data   arbiter -> requester  shared result bus
// master: requester side; slave: arbiter side.
interface exec_arbiter_if
  import exec_arbiter_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int OPW   = DEF_OPW
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*OPW-1:0]   req_op;
  logic [NREQ*WIDTH-1:0] req_in1;
  logic [NREQ*WIDTH-1:0] req_in2;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ-1:0]       rsp_ready;
  logic [WIDTH-1:0]      rsp_data;

  modport master (
    output req_valid, req_op, req_in1, req_in2, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_op, req_in1, req_in2, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/exec_arbiter_pick.sv
// exec_arb_pick
// Combinational grant selection.
//   valid_i  in   NREQ   pending requests
//   ptr_i    in   IDXW   last granted index (round-robin mode only)
//   rr_en_i  in   1      1: search from ptr_i+1 with wrap; 0: lowest index wins
//   grant_o  out  NREQ   one-hot grant, zero when nothing is valid
//   idx_o    out  IDXW   encoded grant index
module exec_arb_pick
  import exec_arbiter_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IDXW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [IDXW-1:0] ptr_i,
  input  logic            rr_en_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDXW-1:0] idx_o
);

  int              j;
  logic            found;
  logic [NREQ-1:0] vs;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    j       = 0;
    vs      = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (rr_en_i) j = (int'(ptr_i) + 1 + i) % NREQ;
      else         j = i;
      vs = valid_i >> j;
      if (!found && vs[0]) begin
        found   = 1'b1;
        grant_o = NREQ'(1) << j;
        idx_o   = IDXW'(j);
      end
    end
  end

endmodule

// File: rtl/exec_arbiter.sv
// exec_arbiter
// Shares one `exec` ALU between NREQ requesters: accepts one operation,
// drives `exec` from registered operands, waits EXEC_LAT+1 cycles, captures
// the result and returns it to the granted requester.
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          exec_arbiter_if.slave request/response channels
//   exec_op_o    op to `exec`
//   exec_in1_o   in1 to `exec`
//   exec_in2_o   in2 to `exec`
//   exec_out_i   result from `exec`
//   busy_o       high whenever not idle
// Build option: EXEC_ARB_RR_EN selects round-robin grant; undefined gives
// fixed lowest-index priority with no pointer register.
//
// state | meaning
// IDLE  | waiting for a request, grant given combinationally
// EXEC  | operands on exec_*, counting EXEC_LAT+1 cycles
// RESP  | result held on rsp_data until the granted requester takes it
module exec_arbiter
  import exec_arbiter_pkg::*;
#(
  parameter int NREQ     = DEF_NREQ,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int OPW      = DEF_OPW,
  parameter int EXEC_LAT = DEF_EXEC_LAT
) (
  input  logic             clk,
  input  logic             rst_n,
  exec_arbiter_if.slave    bus,
  output logic [OPW-1:0]   exec_op_o,
  output logic [WIDTH-1:0] exec_in1_o,
  output logic [WIDTH-1:0] exec_in2_o,
  input  logic [WIDTH-1:0] exec_out_i,
  output logic             busy_o
);

  localparam int IDXW = $clog2(NREQ);
  localparam int CNTW = $clog2(EXEC_LAT + 1);

  arb_state_e         state_q, state_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic [OPW-1:0]     op_q, op_d;
  logic [WIDTH-1:0]   in1_q, in1_d, in2_q, in2_d, res_q, res_d;
  logic [IDXW-1:0]    gnt_q, gnt_d;
  logic [IDXW-1:0]    ptr_q;
  logic [NREQ-1:0]    pick_grant;
  logic [IDXW-1:0]    pick_idx;
  logic [NREQ-1:0]    req_ready_c, rsp_valid_c, rsp_sel;
  logic [NREQ*OPW-1:0]   op_sh;
  logic [NREQ*WIDTH-1:0] in1_sh, in2_sh;

`ifdef EXEC_ARB_RR_EN
  localparam logic RR_EN = 1'b1;
  logic [IDXW-1:0] ptr_d;

  // Pointer moves only when a request is actually accepted.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == ST_IDLE && (|bus.req_valid)) ptr_d = pick_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= IDXW'(NREQ - 1);
    else        ptr_q <= ptr_d;
  end
`else
  localparam logic RR_EN = 1'b0;
  assign ptr_q = IDXW'(NREQ - 1);
`endif

  exec_arb_pick #(.NREQ(NREQ), .IDXW(IDXW)) u_pick (
    .valid_i (bus.req_valid),
    .ptr_i   (ptr_q),
    .rr_en_i (RR_EN),
    .grant_o (pick_grant),
    .idx_o   (pick_idx)
  );

  // Select the granted requester's fields by shifting its slot to bit 0.
  assign op_sh   = bus.req_op  >> (int'(pick_idx) * OPW);
  assign in1_sh  = bus.req_in1 >> (int'(pick_idx) * WIDTH);
  assign in2_sh  = bus.req_in2 >> (int'(pick_idx) * WIDTH);
  assign rsp_sel = bus.rsp_ready >> gnt_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    in1_d       = in1_q;
    in2_d       = in2_q;
    res_d       = res_q;
    gnt_d       = gnt_q;
    req_ready_c = '0;
    rsp_valid_c = '0;
    case (state_q)
      ST_IDLE: begin
        if (|bus.req_valid) begin
          req_ready_c = pick_grant;
          op_d        = op_sh[OPW-1:0];
          in1_d       = in1_sh[WIDTH-1:0];
          in2_d       = in2_sh[WIDTH-1:0];
          gnt_d       = pick_idx;
          cnt_d       = '0;
          state_d     = ST_EXEC;
        end
      end
      ST_EXEC: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNTW'(EXEC_LAT)) begin
          res_d   = exec_out_i;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid_c = NREQ'(1) << gnt_q;
        if (rsp_sel[0]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      in1_q   <= '0;
      in2_q   <= '0;
      res_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      res_q   <= res_d;
      gnt_q   <= gnt_d;
    end
  end

  // Grant is combinational from req_valid, so mask it while reset is held.
  assign bus.req_ready = rst_n ? req_ready_c : '0;
  assign bus.rsp_valid = rsp_valid_c;
  assign bus.rsp_data  = res_q;
  assign exec_op_o     = op_q;
  assign exec_in1_o    = in1_q;
  assign exec_in2_o    = in2_q;
  assign busy_o        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_exec_arbiter.sv
// tb_exec_arbiter
// Bench for exec_arbiter with a behavioural `exec` ALU model, directed
// vectors, multi-cycle corner sequences and a randomized phase checked
// against a transaction-level reference model. Honors EXEC_ARB_RR_EN.
module tb_exec_arbiter;
  import exec_arbiter_pkg::*;

  localparam int NREQ = 2, WIDTH = 32, OPW = 6, EXEC_LAT = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [OPW-1:0]   exec_op;
  logic [WIDTH-1:0] exec_in1, exec_in2, exec_out;
  logic             busy;

  exec_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .OPW(OPW)) bus ();

  exec_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .OPW(OPW), .EXEC_LAT(EXEC_LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .exec_op_o  (exec_op),
    .exec_in1_o (exec_in1),
    .exec_in2_o (exec_in2),
    .exec_out_i (exec_out),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] alu(input logic [OPW-1:0] op,
                                           input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_XOR:  return a ^ b;
      default: return '0;
    endcase
  endfunction

  // `exec` with EXEC_LAT registered stages
  logic [WIDTH-1:0] pipe [EXEC_LAT];
  always @(posedge clk) begin
    pipe[0] <= alu(exec_op, exec_in1, exec_in2);
    for (int k = 1; k < EXEC_LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign exec_out = pipe[EXEC_LAT-1];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [NREQ-1:0] ref_pick(input logic [NREQ-1:0] v, input int last);
    logic [NREQ-1:0] s;
`ifdef EXEC_ARB_RR_EN
    for (int k = 1; k <= NREQ; k++) begin
      int j;
      j = (last + k) % NREQ;
      s = v >> j;
      if (s[0]) return NREQ'(1) << j;
    end
`else
    for (int j = 0; j < NREQ; j++) begin
      s = v >> j;
      if (s[0]) return NREQ'(1) << j;
    end
`endif
    return '0;
  endfunction

  task automatic set_req(input int i, input logic [OPW-1:0] op,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bus.req_op[i*OPW +: OPW]      = op;
    bus.req_in1[i*WIDTH +: WIDTH] = a;
    bus.req_in2[i*WIDTH +: WIDTH] = b;
  endtask

  task automatic clear_inputs();
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_in1   = '0;
    bus.req_in2   = '0;
    bus.rsp_ready = '1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    clear_inputs();
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    check("wait_idle timeout", ok, 1'b1);
  endtask

  typedef struct {
    int               idx;
    logic [OPW-1:0]   op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] exp;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input vec_t v);
    @(posedge clk); #1;
    clear_inputs();
    bus.req_valid = NREQ'(1) << v.idx;
    set_req(v.idx, v.op, v.a, v.b);
    @(negedge clk);
    check("vec accept", bus.req_ready, NREQ'(1) << v.idx);
    @(posedge clk); #1;
    bus.req_valid = '0;
    @(negedge clk);
    check("vec exec_op", exec_op, v.op);
    check("vec exec_in1", exec_in1, v.a);
    check("vec exec_in2", exec_in2, v.b);
    check("vec busy", busy, 1'b1);
    check("vec rsp early", bus.rsp_valid, '0);
    for (int k = 0; k < EXEC_LAT; k++) begin
      @(negedge clk);
      check("vec rsp early", bus.rsp_valid, '0);
    end
    @(negedge clk);
    check("vec rsp_valid", bus.rsp_valid, NREQ'(1) << v.idx);
    check("vec rsp_data", bus.rsp_data, v.exp);
    @(negedge clk);
    check("vec busy after", busy, 1'b0);
    check("vec rsp after", bus.rsp_valid, '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int               n_got;
    int               g_idx [4];
    logic [WIDTH-1:0] g_dat [4];
    int               g_cyc [4];
    bit               saw_r1, ok, saw_rsp;
    logic             m_have;
    int               m_acc, m_idx, m_last;
    logic [OPW-1:0]   m_op;
    logic [WIDTH-1:0] m_a, m_b, m_data;
    logic [NREQ-1:0]  eg, erv;

    vecs[0] = '{0, OP_ADD, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003};
    vecs[1] = '{1, OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
    vecs[2] = '{0, OP_SUB, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE};
    vecs[3] = '{1, OP_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0};
    vecs[4] = '{0, OP_AND, 32'h1234_5678, 32'h0000_FFFF, 32'h0000_5678};
    vecs[5] = '{1, OP_ADD, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000};

    // Reset with requests pending: everything must read zero.
    clear_inputs();
    bus.req_valid = '1;
    set_req(0, OP_SUB, 32'h11, 32'h22);
    set_req(1, OP_XOR, 32'h33, 32'h44);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset req_ready", bus.req_ready, '0);
    check("reset rsp_valid", bus.rsp_valid, '0);
    check("reset rsp_data", bus.rsp_data, '0);
    check("reset exec_op", exec_op, '0);
    check("reset exec_in1", exec_in1, '0);
    check("reset exec_in2", exec_in2, '0);
    check("reset busy", busy, 1'b0);
    clear_inputs();
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Contention: both requesters continuously valid.
    do_reset();
    @(posedge clk); #1;
    bus.req_valid = '1;
    set_req(0, OP_ADD, 32'd5, 32'd1);
    set_req(1, OP_ADD, 32'd7, 32'd1);
    n_got  = 0;
    saw_r1 = 1'b0;
    for (int c = 0; c < 80 && n_got < 4; c++) begin
      @(negedge clk);
      if (bus.req_ready[1]) saw_r1 = 1'b1;
      if (bus.rsp_valid != '0) begin
        g_idx[n_got] = bus.rsp_valid[1] ? 1 : 0;
        g_dat[n_got] = bus.rsp_data;
        g_cyc[n_got] = c;
        n_got++;
      end
    end
    check("contention count", n_got, 4);
    for (int k = 0; k < n_got; k++) begin
`ifdef EXEC_ARB_RR_EN
      check("contention idx", g_idx[k], k % 2);
      check("contention data", g_dat[k], (k % 2) ? 32'd8 : 32'd6);
`else
      check("contention idx", g_idx[k], 0);
      check("contention data", g_dat[k], 32'd6);
`endif
      if (k > 0) check("contention spacing", g_cyc[k] - g_cyc[k-1], EXEC_LAT + 3);
    end
`ifdef EXEC_ARB_RR_EN
    check("contention req1 granted", saw_r1, 1'b1);
`else
    check("contention req1 starved", saw_r1, 1'b0);
`endif
    wait_idle();

    // Backpressure: rsp_ready[0] low for 5 cycles; ready on other index ignored.
    @(posedge clk); #1;
    bus.req_valid = 2'b01;
    set_req(0, OP_ADD, 32'd1, 32'd2);
    bus.rsp_ready = '0;
    @(negedge clk);
    check("bp accept", bus.req_ready, 2'b01);
    @(posedge clk); #1;
    bus.req_valid = 2'b10;
    set_req(1, OP_ADD, 32'd7, 32'd1);
    bus.rsp_ready = 2'b10;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.rsp_valid != '0) begin ok = 1'b1; break; end
    end
    check("bp rsp timeout", ok, 1'b1);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      check("bp rsp_valid held", bus.rsp_valid, 2'b01);
      check("bp rsp_data held", bus.rsp_data, 32'd3);
      check("bp req_ready", bus.req_ready, '0);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 2'b11;
    @(negedge clk);
    check("bp 6th rsp_valid", bus.rsp_valid, 2'b01);
    check("bp 6th req_ready", bus.req_ready, '0);
    @(negedge clk);
    check("bp done rsp_valid", bus.rsp_valid, '0);
    check("bp done busy", busy, 1'b0);
    check("bp next accept", bus.req_ready, 2'b10);
    wait_idle();

    // Reset in the first EXEC cycle aborts the operation.
    @(posedge clk); #1;
    bus.req_valid = 2'b01;
    set_req(0, OP_SUB, 32'd9, 32'd4);
    @(negedge clk);
    check("rst accept", bus.req_ready, 2'b01);
    @(posedge clk); #1;
    check("rst exec_op before", exec_op, OP_SUB);
    rst_n = 1'b0;
    #1;
    check("rst req_ready", bus.req_ready, '0);
    check("rst rsp_valid", bus.rsp_valid, '0);
    check("rst rsp_data", bus.rsp_data, '0);
    check("rst exec_op", exec_op, '0);
    check("rst exec_in1", exec_in1, '0);
    check("rst exec_in2", exec_in2, '0);
    check("rst busy", busy, 1'b0);
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b1;
    saw_rsp = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.rsp_valid != '0 || busy) saw_rsp = 1'b1;
    end
    check("rst no response", saw_rsp, 1'b0);

    // Randomized traffic against a transaction-level model.
    do_reset();
    m_have = 1'b0;
    m_last = NREQ - 1;
    m_acc  = 0;
    m_idx  = 0;
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      bus.req_valid = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++)
        set_req(i, OPW'($urandom_range(0, 3)),
                ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom, $urandom);
      bus.rsp_ready = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      @(negedge clk);
      if (!m_have) begin
        eg = ref_pick(bus.req_valid, m_last);
        check("rnd req_ready", bus.req_ready, eg);
        check("rnd busy idle", busy, 1'b0);
        check("rnd rsp_valid idle", bus.rsp_valid, '0);
        if (eg != '0) begin
          for (int j = 0; j < NREQ; j++) if (eg[j]) m_idx = j;
          m_have = 1'b1;
          m_acc  = c;
          m_op   = bus.req_op[m_idx*OPW +: OPW];
          m_a    = bus.req_in1[m_idx*WIDTH +: WIDTH];
          m_b    = bus.req_in2[m_idx*WIDTH +: WIDTH];
          m_data = alu(m_op, m_a, m_b);
          m_last = m_idx;
        end
      end else begin
        check("rnd req_ready busy", bus.req_ready, '0);
        check("rnd busy", busy, 1'b1);
        if (c > m_acc) begin
          check("rnd exec_op", exec_op, m_op);
          check("rnd exec_in1", exec_in1, m_a);
          check("rnd exec_in2", exec_in2, m_b);
        end
        erv = (c >= m_acc + EXEC_LAT + 2) ? (NREQ'(1) << m_idx) : '0;
        check("rnd rsp_valid", bus.rsp_valid, erv);
        if (erv != '0) begin
          check("rnd rsp_data", bus.rsp_data, m_data);
          if (bus.rsp_ready[m_idx]) m_have = 1'b0;
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
